// File: rtl/arcino_prefetch_ctrl_if.sv
// Instruction-memory request bus and fetch-FIFO push port for the prefetch controller.
// master = controller side, slave = memory / FIFO side.
interface arcino_prefetch_ctrl_if;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;

   logic        fifo_valid_o;
   logic [31:0] fifo_addr_o;
   logic [31:0] fifo_rdata_o;
   logic        fifo_ready_i;
   logic        fifo_clear_o;

   modport master (
      output instr_req_o, instr_addr_o,
      input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
      output fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_clear_o,
      input  fifo_ready_i
   );

   modport slave (
      input  instr_req_o, instr_addr_o,
      output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
      input  fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_clear_o,
      output fifo_ready_i
   );
endinterface

// File: rtl/arcino_prefetch_ctrl.sv
// Instruction prefetch controller: one outstanding req/gnt/rvalid transaction,
// zero-latency push of returned words into the fetch FIFO, branch redirect with abort.
module arcino_prefetch_ctrl #(
   parameter logic [31:0] RESET_FETCH_ADDR = 32'h0000_0000
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          req_i,
   input  logic                          branch_i,
   input  logic [31:0]                   branch_addr_i,
   output logic                          busy_o,
   arcino_prefetch_ctrl_if.master        bus
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_GNT     = 2'd1,
      WAIT_RVALID  = 2'd2,
      WAIT_ABORTED = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] tgt_q, tgt_d;
   logic        abort_q, abort_d;

   logic        issue;
   logic        req;
   logic        gnt;
   logic        push;
   logic [31:0] branch_tgt;
   logic        unused_baddr0;

   assign unused_baddr0 = branch_addr_i[0];
   assign branch_tgt    = {branch_addr_i[31:1], 1'b0};
   assign issue         = req_i & bus.fifo_ready_i & ~branch_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         fetch_addr_q <= {RESET_FETCH_ADDR[31:2], 2'b00};
         addr_q       <= '0;
         tgt_q        <= '0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         addr_q       <= addr_d;
         tgt_q        <= tgt_d;
         abort_q      <= abort_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      addr_d       = addr_q;
      tgt_d        = tgt_q;
      abort_d      = abort_q;
      req          = 1'b0;
      push         = 1'b0;

      case (state_q)
         IDLE: begin
            req = issue;
         end
         WAIT_GNT: begin
            req = 1'b1;
         end
         WAIT_RVALID: begin
            req  = issue & bus.instr_rvalid_i;
            push = bus.instr_rvalid_i & ~branch_i;
            if (bus.instr_rvalid_i)
               state_d = IDLE;
            else if (branch_i)
               state_d = WAIT_ABORTED;
         end
         WAIT_ABORTED: begin
            req = issue & bus.instr_rvalid_i;
            if (bus.instr_rvalid_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      gnt = req & bus.instr_gnt_i;

      // A request issued back-to-back with a response overrides the return to IDLE.
      if (req) begin
         if (gnt)
            state_d = (abort_q | branch_i) ? WAIT_ABORTED : WAIT_RVALID;
         else
            state_d = WAIT_GNT;
      end

      if (gnt) begin
         addr_d       = fetch_addr_q;
         abort_d      = 1'b0;
         fetch_addr_d = abort_q ? tgt_q : {fetch_addr_q[31:2] + 30'h1, 2'b00};
      end

      // instr_addr_o is held while a request waits for grant, so the target is
      // parked in tgt_q and applied when that request is finally granted.
      if (branch_i) begin
         if ((state_q == WAIT_GNT) && !gnt) begin
            tgt_d   = branch_tgt;
            abort_d = 1'b1;
         end else begin
            fetch_addr_d = branch_tgt;
         end
      end
   end

   assign bus.instr_req_o  = req;
   assign bus.instr_addr_o = {fetch_addr_q[31:2], 2'b00};
   assign bus.fifo_valid_o = push;
   // Address/data are zeroed when not pushing so the push port is quiet in reset and idle.
   assign bus.fifo_addr_o  = push ? addr_q : 32'h0;
   assign bus.fifo_rdata_o = push ? bus.instr_rdata_i : 32'h0;
   assign bus.fifo_clear_o = branch_i;
   assign busy_o           = (state_q != IDLE);

   a_rvalid_expected: assert property (@(posedge clk_i) disable iff (rst_i)
      bus.instr_rvalid_i |-> ((state_q == WAIT_RVALID) || (state_q == WAIT_ABORTED)));

   a_push_has_room: assert property (@(posedge clk_i) disable iff (rst_i)
      bus.fifo_valid_o |-> (bus.fifo_ready_i || (state_q == WAIT_RVALID)));

endmodule

// File: tb/tb_arcino_prefetch_ctrl.sv
// Bench for arcino_prefetch_ctrl: directed scenarios then random traffic, all checked
// against a transaction-level model (held request, outstanding response, fetch pointer).
module tb_arcino_prefetch_ctrl;

   logic        clk_i;
   logic        rst_i;
   logic        req_i;
   logic        branch_i;
   logic [31:0] branch_addr_i;
   logic        busy_o;

   arcino_prefetch_ctrl_if bus ();

   arcino_prefetch_ctrl #(.RESET_FETCH_ADDR(32'h0000_0000)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_i         (req_i),
      .branch_i      (branch_i),
      .branch_addr_i (branch_addr_i),
      .busy_o        (busy_o),
      .bus           (bus.master)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: the fetch pointer, a request waiting for grant, and the single
   // granted transaction awaiting its word; each knows whether a branch killed it.
   logic [31:0] m_fetch, m_tgt, m_out_addr;
   bit          m_hold, m_hold_drop, m_out, m_out_drop;

   // Outputs captured at the most recent step, for scenario-specific checks.
   logic        s_req, s_push, s_busy, s_clear;
   logic [31:0] s_addr, s_paddr, s_pdata;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fetch = 32'h0; m_tgt = 32'h0; m_out_addr = 32'h0;
      m_hold = 0; m_hold_drop = 0; m_out = 0; m_out_drop = 0;
   endtask

   task automatic chk_quiet(input string tag);
      chk1 ({tag, "_req"},   bus.instr_req_o,  1'b0);
      chk32({tag, "_addr"},  bus.instr_addr_o, 32'h0);
      chk1 ({tag, "_valid"}, bus.fifo_valid_o, 1'b0);
      chk32({tag, "_faddr"}, bus.fifo_addr_o,  32'h0);
      chk32({tag, "_fdata"}, bus.fifo_rdata_o, 32'h0);
      chk1 ({tag, "_clear"}, bus.fifo_clear_o, 1'b0);
      chk1 ({tag, "_busy"},  busy_o,           1'b0);
   endtask

   // One clock: drive at negedge, check #1 later, advance the model across posedge.
   task automatic step(input bit req, input bit br, input logic [31:0] baddr,
                       input bit gnt, input bit rv, input logic [31:0] rd, input bit rdy);
      bit          issue, e_req, e_push, granted;
      logic [31:0] tgt;
      req_i = req; branch_i = br; branch_addr_i = baddr;
      bus.instr_gnt_i = gnt; bus.instr_rvalid_i = rv; bus.instr_rdata_i = rd;
      bus.fifo_ready_i = rdy;
      #1;
      issue  = req & rdy & ~br;
      e_req  = m_hold ? 1'b1 : (m_out ? (issue & rv) : issue);
      e_push = m_out & rv & ~m_out_drop & ~br;
      chk1 ("instr_req",  bus.instr_req_o,  e_req);
      chk32("instr_addr", bus.instr_addr_o, {m_fetch[31:2], 2'b00});
      chk1 ("busy",       busy_o,           m_hold | m_out);
      chk1 ("fifo_clear", bus.fifo_clear_o, br);
      chk1 ("fifo_valid", bus.fifo_valid_o, e_push);
      if (e_push) begin
         chk32("fifo_addr",  bus.fifo_addr_o,  m_out_addr);
         chk32("fifo_rdata", bus.fifo_rdata_o, rd);
      end
      s_req = bus.instr_req_o; s_addr = bus.instr_addr_o; s_push = bus.fifo_valid_o;
      s_paddr = bus.fifo_addr_o; s_pdata = bus.fifo_rdata_o;
      s_busy = busy_o; s_clear = bus.fifo_clear_o;
      @(posedge clk_i);
      granted = e_req & gnt;
      tgt = {baddr[31:1], 1'b0};
      if (m_out && rv) m_out = 0;
      else if (m_out && br) m_out_drop = 1;
      if (granted) begin
         m_out = 1; m_out_addr = m_fetch; m_out_drop = m_hold_drop | br;
         m_fetch = m_hold_drop ? m_tgt : {m_fetch[31:2] + 30'd1, 2'b00};
         m_hold = 0; m_hold_drop = 0;
      end else if (e_req) begin
         m_hold = 1;
      end
      if (br) begin
         if (e_req && !granted) begin m_tgt = tgt; m_hold_drop = 1; end
         else m_fetch = tgt;
      end
      @(negedge clk_i);
   endtask

   initial begin
      rst_i = 1'b1; req_i = 0; branch_i = 0; branch_addr_i = 0;
      bus.instr_gnt_i = 0; bus.instr_rvalid_i = 0; bus.instr_rdata_i = 0; bus.fifo_ready_i = 0;
      model_reset();
      @(negedge clk_i);
      #1;
      chk_quiet("reset");
      @(negedge clk_i);
      rst_i = 1'b0;

      // Basic fetch: gnt and rvalid each one cycle after the request.
      step(1,0,0, 0,0,32'h0,1);          chk1("b_req0", s_req, 1); chk32("b_addr0", s_addr, 32'h0);
      step(1,0,0, 1,0,32'h0,1);          chk32("b_addr0g", s_addr, 32'h0);
      step(1,0,0, 0,1,32'hA5A5_0001,1);  chk1("b_push0", s_push, 1); chk32("b_paddr0", s_paddr, 32'h0);
                                         chk32("b_pdata0", s_pdata, 32'hA5A5_0001); chk32("b_addr1", s_addr, 32'h4);
      step(1,0,0, 1,0,32'h0,1);          chk32("b_addr1g", s_addr, 32'h4);
      step(0,0,0, 0,1,32'hA5A5_0002,1);  chk32("b_paddr1", s_paddr, 32'h4); chk32("b_pdata1", s_pdata, 32'hA5A5_0002);

      // Branch in IDLE to a half-word target.
      step(1,1,32'h102, 0,0,32'h0,1);    chk1("bi_clear", s_clear, 1); chk1("bi_noreq", s_req, 0);
      step(1,0,0, 1,0,32'h0,1);          chk1("bi_req", s_req, 1); chk32("bi_addr", s_addr, 32'h100);
      step(1,0,0, 1,1,32'h1111_2222,1);  chk32("bi_paddr", s_paddr, 32'h102); chk32("bi_next", s_addr, 32'h104);
      step(0,0,0, 0,1,32'h3333_4444,1);  chk32("bi_paddr2", s_paddr, 32'h104);

      // Branch while waiting for rvalid: that response is dropped.
      step(1,0,0, 1,0,32'h0,1);          chk32("br_addr", s_addr, 32'h108);
      step(1,1,32'h200, 0,0,32'h0,1);    chk1("br_busy0", s_busy, 1); chk1("br_noreq", s_req, 0);
      step(1,0,0, 0,0,32'h0,1);          chk1("br_busy1", s_busy, 1);
      step(1,0,0, 1,1,32'hDEAD_BEEF,1);  chk1("br_drop", s_push, 0); chk32("br_tgt", s_addr, 32'h200);
      step(0,0,0, 0,1,32'h0BAD_F00D,1);  chk32("br_paddr", s_paddr, 32'h200);

      // Branch while waiting for grant (gnt low 3 cycles): address held, response dropped.
      step(1,0,0, 0,0,32'h0,1);          chk32("bg_addr0", s_addr, 32'h204);
      step(1,1,32'h300, 0,0,32'h0,1);    chk32("bg_addr1", s_addr, 32'h204); chk1("bg_req1", s_req, 1);
      step(1,0,0, 0,0,32'h0,1);          chk32("bg_addr2", s_addr, 32'h204);
      step(1,0,0, 1,0,32'h0,1);          chk32("bg_addr3", s_addr, 32'h204);
      step(1,0,0, 0,1,32'h5555_6666,1);  chk1("bg_drop", s_push, 0); chk32("bg_tgt", s_addr, 32'h300);
      step(1,0,0, 1,0,32'h0,1);          chk32("bg_tgtg", s_addr, 32'h300);
      step(0,0,0, 0,1,32'h7777_8888,1);  chk32("bg_paddr", s_paddr, 32'h300);

      // FIFO full: no issue; outstanding response still pushed.
      for (int i = 0; i < 4; i++) begin
         step(1,0,0, 1,0,32'h0,0);       chk1("ff_noreq", s_req, 0);
      end
      step(1,0,0, 1,0,32'h0,1);          chk1("ff_req", s_req, 1); chk32("ff_addr", s_addr, 32'h304);
      step(0,0,0, 0,1,32'h9999_AAAA,0);  chk1("ff_push", s_push, 1); chk32("ff_paddr", s_paddr, 32'h304);

      // Address wrap at the top of memory.
      step(0,1,32'hFFFF_FFF8, 0,0,32'h0,1);
      step(1,0,0, 1,0,32'h0,1);          chk32("w_addr0", s_addr, 32'hFFFF_FFF8);
      step(1,0,0, 1,1,32'h1,1);          chk32("w_addr1", s_addr, 32'hFFFF_FFFC);
      step(1,0,0, 1,1,32'h2,1);          chk32("w_wrap", s_addr, 32'h0); chk32("w_paddr", s_paddr, 32'hFFFF_FFFC);

      // Reset in WAIT_RVALID: everything returns to zero at once.
      rst_i = 1'b1; req_i = 0; branch_i = 0; bus.instr_gnt_i = 0; bus.instr_rvalid_i = 0;
      #1;
      chk_quiet("midrst");
      model_reset();
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Random traffic; rvalid only ever offered while a response is outstanding.
      for (int i = 0; i < 3000; i++) begin
         bit rv;
         logic [31:0] ba;
         rv = m_out ? 1'($urandom_range(0, 1)) : 1'b0;
         ba = $urandom;
         step(($urandom_range(0, 9) < 8), ($urandom_range(0, 15) == 0), ba,
              1'($urandom_range(0, 1)), rv, $urandom, ($urandom_range(0, 9) < 8));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/arcino_prefetch_ctrl.md
Name: arcino_prefetch_ctrl

Overview:
- Instruction-fetch request controller that sits directly upstream of the core's fetch FIFO.
- Drives the 32-bit instruction memory request/grant/rvalid bus with at most one outstanding request.
- Tags each returned word with its fetch address and pushes it into the fetch FIFO.
- Handles branches: redirects the fetch address, clears the FIFO, and discards the response of any in-flight request.

Parameters:
RESET_FETCH_ADDR, 32'h0000_0000, fetch address loaded at reset (bits [1:0] forced to 0)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset, asynchronous, active-high
req_i  input  1  fetch enable from controller; new requests are issued only while high
branch_i  input  1  redirect fetch this cycle (single-cycle pulse)
branch_addr_i  input  32  branch target; bit 1 may be set, bit 0 ignored
busy_o  output  1  high whenever a memory transaction is pending (state != IDLE)
instr_req_o  output  1  memory request
instr_addr_o  output  32  word-aligned memory address
instr_gnt_i  input  1  memory grant
instr_rvalid_i  input  1  memory read data valid
instr_rdata_i  input  32  memory read data
fifo_valid_o  output  1  push to fetch FIFO
fifo_addr_o  output  32  address of pushed word (bit 1 carries branch misalignment)
fifo_rdata_o  output  32  pushed word (equals instr_rdata_i)
fifo_ready_i  input  1  FIFO has space
fifo_clear_o  output  1  FIFO clear, equals branch_i combinationally

Behaviour:
- Reset values:
  - state=IDLE, fetch_addr_q=RESET_FETCH_ADDR, addr_q=0, abort_q=0.
  - All outputs 0, except instr_addr_o={fetch_addr_q[31:2],2'b00}.
- States: IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORTED.
- Issue condition: issue = req_i & fifo_ready_i & ~branch_i. instr_req_o is driven combinationally:
  - 1 in WAIT_GNT.
  - = issue in IDLE.
  - = issue & instr_rvalid_i in WAIT_RVALID or WAIT_ABORTED.
- instr_addr_o is {fetch_addr_q[31:2],2'b00} and must stay stable while in WAIT_GNT.
- Grant (instr_req_o & instr_gnt_i):
  - addr_q <= fetch_addr_q (bit 1 kept).
  - fetch_addr_q <= {fetch_addr_q[31:2]+30'h1,2'b00}; the increment wraps modulo 2^32.
  - Next state WAIT_RVALID, or WAIT_ABORTED if abort_q or branch_i.
- Request without grant: next state WAIT_GNT.
- IDLE with no issue: stay IDLE.
- WAIT_RVALID with instr_rvalid_i and branch_i=0:
  - fifo_valid_o=1, fifo_addr_o=addr_q, fifo_rdata_o=instr_rdata_i, all in the same cycle (zero-latency pass-through).
  - Without a new grant, go to IDLE.
- WAIT_ABORTED with instr_rvalid_i: data is dropped (fifo_valid_o=0); go to IDLE or issue a new request as above.
- fifo_valid_o is never asserted outside WAIT_RVALID, and never when branch_i=1.
- Branch (branch_i=1):
  - fifo_clear_o=1.
  - fetch_addr_q <= {branch_addr_i[31:1],1'b0}, so the first pushed word after the branch carries bit 1 from the target.
  - IDLE: no request this cycle; next cycle requests the target.
  - WAIT_GNT: request and address held. abort_q <= 1, so the eventual grant goes to WAIT_ABORTED. abort_q clears on that grant.
  - WAIT_RVALID without rvalid: go to WAIT_ABORTED.
  - WAIT_RVALID with rvalid: data dropped; go to IDLE.
  - WAIT_ABORTED: stay, unless rvalid arrives, then go to IDLE.
  - Branch while abort_q=1: target updated; abort_q stays 1.
- fifo_ready_i low: no new requests are issued. An outstanding response is still pushed, because the FIFO reserves one entry of slack.
- req_i low: the outstanding transaction completes normally; no further issue.
- Reset asserted mid-transaction: immediate return to IDLE with reset values. Late rvalids are not tracked and must not occur.
- busy_o = (state != IDLE).
- Assertions:
  - instr_rvalid_i only in WAIT_RVALID or WAIT_ABORTED.
  - fifo_valid_o implies fifo_ready_i or a response already in flight.

Test Plan:
- Reset, req_i=1, gnt and rvalid each one cycle after req -> first request at addr 0x0, next at 0x4; pushes {addr 0x0, then 0x4} with matching rdata.
- branch_i with branch_addr_i=0x102 while in IDLE -> fifo_clear_o=1 that cycle; next request at 0x100, pushed with fifo_addr_o=0x102, following request at 0x104.
- Branch while WAIT_RVALID (rvalid two cycles later) -> that rvalid is not pushed; next request goes to the target; busy_o high throughout.
- Branch while WAIT_GNT with gnt held low for 3 cycles -> instr_addr_o stable at the old address; the granted response is dropped; target fetched afterwards.
- fifo_ready_i=0 for 4 cycles with req_i=1 -> no instr_req_o; on fifo_ready_i=1 a request is issued the same cycle.
- fetch_addr near 0xFFFF_FFFC -> next request wraps to 0x0000_0000; rst_i asserted during WAIT_RVALID -> outputs zero immediately and state is IDLE.
